// File: rtl/key_pulse_gen.sv
// Push-button conditioner: 2-flop sync + debounce on five keys, direction keys
// become single-cycle pulses with auto-repeat, play key toggles a run/stop level.
module key_pulse_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned REPEAT_DELAY    = 12500000,
   parameter int unsigned REPEAT_PERIOD   = 2500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_left,
   input  logic key_right,
   input  logic key_up,
   input  logic key_down,
   input  logic key_play,
   output logic left,
   output logic right,
   output logic up,
   output logic down,
   output logic play
);

   localparam int NKEYS = 5;
   localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0] RD_LAST = 32'(REPEAT_DELAY - 1);
   localparam logic [31:0] RP_LAST = 32'(REPEAT_PERIOD - 1);

   // Bit order: 0 left, 1 right, 2 up, 3 down, 4 play.
   logic [NKEYS-1:0] raw_keys;
   logic [NKEYS-1:0] sync1_q;
   logic [NKEYS-1:0] sync2_q;
   logic [NKEYS-1:0] stable;

   assign raw_keys = {key_play, key_down, key_up, key_right, key_left};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw_keys;
         sync2_q <= sync1_q;
      end
   end

   for (genvar gi = 0; gi < NKEYS; gi++) begin : g_debounce
      logic [31:0] cnt_q;
      logic        stable_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
         end else if (sync2_q[gi] == stable_q) begin
            cnt_q <= '0;
         end else if (cnt_q >= DB_LAST) begin
            stable_q <= sync2_q[gi];
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + 32'd1;
         end
      end

      assign stable[gi] = stable_q;
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [31:0] timer_q, timer_d;
   logic [3:0]  pulse_q, pulse_d;
   logic [3:0]  dir_stable;
   logic        play_prev_q;
   logic        play_q;

   assign dir_stable = stable[3:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
         timer_q <= '0;
         pulse_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         timer_q <= timer_d;
         pulse_q <= pulse_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      timer_d = timer_q;
      pulse_d = '0;
      case (state_q)
         IDLE: begin
            if (|dir_stable) begin
               // Same priority order as the tempo adjuster: left > right > down > up.
               if (dir_stable[0])      sel_d = 2'd0;
               else if (dir_stable[1]) sel_d = 2'd1;
               else if (dir_stable[3]) sel_d = 2'd3;
               else                    sel_d = 2'd2;
               pulse_d = 4'b0001 << sel_d;
               timer_d = RD_LAST;
               state_d = HOLD;
            end
         end
         HOLD, REPEAT: begin
            if (!dir_stable[sel_q]) begin
               state_d = IDLE;
            end else if (timer_q == 32'd0) begin
               pulse_d = 4'b0001 << sel_q;
               timer_d = RP_LAST;
               state_d = REPEAT;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         play_prev_q <= 1'b0;
         play_q      <= 1'b0;
      end else begin
         play_prev_q <= stable[4];
         if (stable[4] && !play_prev_q) begin
            play_q <= !play_q;
         end
      end
   end

   assign left  = pulse_q[0];
   assign right = pulse_q[1];
   assign up    = pulse_q[2];
   assign down  = pulse_q[3];
   assign play  = play_q;

endmodule
